nlb_txq_split_fifo: RTL and testbench
=====================================

NLB_TXQ_SPLIT_FIFO -- requirements
Module: nlb_txq_split_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 552: payload bits per entry.
REQ-002 SHALL have parameter CTL_WIDTH, default 8: control bits per entry; minimum 1.
REQ-003 SHALL have parameter DEPTH_BASE2, default 9: capacity is 2**DEPTH_BASE2 entries.
REQ-004 SHALL have parameter DATA_LAT, default 2: ack-to-data latency in clocks; legal values 1..3.
REQ-005 SHALL have parameter FULL_THRESH, default 2**DEPTH_BASE2-8: almost-full level.
REQ-006 SHALL have parameter EMPTY_THRESH, default 1: almost-empty level.
REQ-007 Clk  in  1  clock; all logic is rising-edge.
REQ-008 Resetb  in  1  reset, synchronous, active-low.
REQ-009 fifo_din  in  DATA_WIDTH  write payload.
REQ-010 fifo_ctlin  in  CTL_WIDTH  write control.
REQ-011 fifo_wen  in  1  write request.
REQ-012 fifo_rdack  in  1  pops the head entry.
REQ-013 fifo_flush  in  1  discards all entries.
REQ-014 err_clr  in  1  clears the sticky error flags.
REQ-015 T0_ctlout  out  CTL_WIDTH  head control, registered.
REQ-016 T0_dout_v  out  1  head valid.
REQ-017 TD_dout  out  DATA_WIDTH  payload of an acked entry.
REQ-018 TD_dout_v  out  1  TD_dout valid strobe.
REQ-019 count  out  DEPTH_BASE2+1  occupancy, range 0..2**DEPTH_BASE2.
REQ-020 full, empty, almFull, almEmpty  out  1 each  status flags.
REQ-021 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-022 A write SHALL be accepted iff fifo_wen=1, full=0 and fifo_flush=0; there is no full-bypass, so fifo_rdack does not admit a write while full.
REQ-023 A pop SHALL be accepted iff fifo_rdack=1, T0_dout_v=1 and fifo_flush=0.
REQ-024 Write-to-T0_dout_v latency into an empty FIFO SHALL be 1 clock, with T0_ctlout valid in that same cycle.
REQ-025 After an accepted pop with further entries present, T0_ctlout/T0_dout_v SHALL present the next entry in the following cycle.
- This also applies when the only remaining entry is written in the same cycle as the pop.
- Back-to-back pops SHALL sustain 1 entry/clock.
REQ-026 For a pop in cycle t, TD_dout SHALL carry that entry's payload and TD_dout_v=1 in cycle t+DATA_LAT; TD_dout_v SHALL be 0 otherwise.
REQ-027 count SHALL be registered as count + accepted_write - accepted_pop.
- full = (count == 2**DEPTH_BASE2).
- empty = (count == 0).
REQ-028 almFull SHALL be registered as (next count >= FULL_THRESH).
REQ-029 almEmpty SHALL be registered as (next count <= EMPTY_THRESH).
REQ-030 Read and write pointers SHALL be DEPTH_BASE2 bits and wrap modulo 2**DEPTH_BASE2 without loss of ordering.
REQ-031 fifo_flush SHALL take priority over fifo_wen and fifo_rdack. In the next cycle:
- count=0, empty=1, T0_dout_v=0 and pointers equal;
- almFull and almEmpty take their registered values for count=0.
REQ-032 fifo_flush SHALL NOT cancel a TD_dout_v already in flight; it completes at its scheduled cycle.
REQ-033 fifo_wen while full SHALL drop the write and set overflow.
REQ-034 fifo_rdack while T0_dout_v=0 SHALL be ignored and set underflow.
REQ-035 err_clr SHALL clear overflow and underflow; a same-cycle set wins over clear.
REQ-036 The RAM write enable SHALL be gated by accepted_write only, so entries are never corrupted at full.

Reset
REQ-037 With Resetb=0 at a rising edge, the block SHALL take the following values:
- count=0, empty=1, full=0, almFull=0, almEmpty=1;
- T0_dout_v=0, TD_dout_v=0, overflow=0, underflow=0;
- pointers=0, and the latency pipeline valids are cleared.
REQ-038 A reset mid-operation SHALL discard all entries and all in-flight TD_dout_v strobes.
REQ-039 T0_ctlout, TD_dout and RAM contents SHALL be unreset, and are don't-care while their valid is 0.

Structure
REQ-040 Package nlb_fifo_pkg SHALL hold the DATA_LAT legal range and the localparam for maximum depth.
REQ-041 Illegal parameter values SHALL cause an elaboration-time error.
REQ-042 Payload storage SHALL be one sub-module, nlb_sdp_ram: a simple dual-port inferred RAM with a registered output, parameterised width, depth and RAM style.
- DATA_LAT-1 extra register stages SHALL follow the RAM output.
REQ-043 Control storage SHALL be a logic-style array read combinationally into the T0_ctlout register.

Verification
REQ-044 Empty FIFO, write ctl=0x5A in cycle 0 -> T0_dout_v=1 and T0_ctlout=0x5A in cycle 1; rdack in cycle 1 -> TD_dout_v=1 with the matching payload in cycle 1+DATA_LAT, for each DATA_LAT 1, 2 and 3.
REQ-045 DEPTH_BASE2=3: write 8 entries -> full=1, count=8; ninth write -> dropped, overflow=1; drain 8 -> payloads in order, empty=1.
REQ-046 Count=1 with simultaneous wen and rdack -> T0_dout_v stays 1, T0_ctlout = new entry, count stays 1.
REQ-047 Run 3*2**DEPTH_BASE2 streaming writes and pops at 1/clock -> pointers wrap, data in order, count never exceeds 2.
REQ-048 Count=5 with flush asserted together with wen and rdack -> next cycle count=0 and T0_dout_v=0; a pop acked one cycle earlier still yields TD_dout_v.
REQ-049 rdack while empty -> underflow=1; err_clr then clears it; err_clr coincident with a new underflow leaves it 1.

Source files
------------

// File: rtl/nlb_fifo_pkg.sv
// -----------------------------------------------------------------------------
// nlb_fifo_pkg
// Shared constants for the NLB transmit-queue FIFO family.
// Holds the legal range of the ack-to-data latency, the largest supported
// depth exponent and a helper that checks a latency value.
// No ports (package).
// -----------------------------------------------------------------------------
package nlb_fifo_pkg;

    localparam int DATA_LAT_MIN    = 1;
    localparam int DATA_LAT_MAX    = 3;
    localparam int MAX_DEPTH_BASE2 = 16;

    function automatic bit data_lat_legal(input int lat);
        return (lat >= DATA_LAT_MIN) && (lat <= DATA_LAT_MAX);
    endfunction

endpackage

// File: rtl/nlb_txq_split_fifo_if.sv
// -----------------------------------------------------------------------------
// nlb_txq_split_fifo_if
// Bundles the write, pop, flush and status signals of nlb_txq_split_fifo.
//   master : the producer/consumer side (drives fifo_din..err_clr)
//   slave  : the FIFO side (drives T0_*, TD_*, count and the flags)
// Signals:
//   fifo_din/fifo_ctlin/fifo_wen : write payload, control, request
//   fifo_rdack                   : pops the head entry
//   fifo_flush / err_clr         : discard all entries / clear sticky errors
//   T0_ctlout/T0_dout_v          : head control and head valid
//   TD_dout/TD_dout_v            : payload of an acked entry and its strobe
//   count, full, empty, almFull, almEmpty, overflow, underflow : status
// -----------------------------------------------------------------------------
interface nlb_txq_split_fifo_if #(
    parameter int DATA_WIDTH  = 552,
    parameter int CTL_WIDTH   = 8,
    parameter int DEPTH_BASE2 = 9
);

    logic [DATA_WIDTH-1:0]  fifo_din;
    logic [CTL_WIDTH-1:0]   fifo_ctlin;
    logic                   fifo_wen;
    logic                   fifo_rdack;
    logic                   fifo_flush;
    logic                   err_clr;

    logic [CTL_WIDTH-1:0]   T0_ctlout;
    logic                   T0_dout_v;
    logic [DATA_WIDTH-1:0]  TD_dout;
    logic                   TD_dout_v;
    logic [DEPTH_BASE2:0]   count;
    logic                   full;
    logic                   empty;
    logic                   almFull;
    logic                   almEmpty;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output fifo_din, fifo_ctlin, fifo_wen, fifo_rdack, fifo_flush, err_clr,
        input  T0_ctlout, T0_dout_v, TD_dout, TD_dout_v, count,
        input  full, empty, almFull, almEmpty, overflow, underflow
    );

    modport slave (
        input  fifo_din, fifo_ctlin, fifo_wen, fifo_rdack, fifo_flush, err_clr,
        output T0_ctlout, T0_dout_v, TD_dout, TD_dout_v, count,
        output full, empty, almFull, almEmpty, overflow, underflow
    );

endinterface

// File: rtl/nlb_sdp_ram.sv
// -----------------------------------------------------------------------------
// nlb_sdp_ram
// Simple dual-port inferred RAM: one write port, one read port with a
// registered output. Contents and read register are unreset.
// Ports:
//   Clk      : clock
//   wr_en    : write enable, wr_addr/wr_data written on the rising edge
//   rd_en    : read enable, rd_data <= mem[rd_addr] on the rising edge
//   rd_data  : registered read data (holds while rd_en=0)
// -----------------------------------------------------------------------------
module nlb_sdp_ram
    import nlb_fifo_pkg::*;
#(
    parameter int    WIDTH     = 552,
    parameter int    ADDR_BITS = 9,
    parameter string RAM_STYLE = "block"
) (
    input  logic                 Clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    generate
        if (WIDTH < 1 || ADDR_BITS < 1 || ADDR_BITS > MAX_DEPTH_BASE2) begin : g_bad_geometry
            $error("nlb_sdp_ram: illegal WIDTH=%0d or ADDR_BITS=%0d", WIDTH, ADDR_BITS);
        end
        if (RAM_STYLE != "block" && RAM_STYLE != "distributed" &&
            RAM_STYLE != "registers" && RAM_STYLE != "ultra") begin : g_bad_style
            $error("nlb_sdp_ram: unsupported RAM_STYLE");
        end
    endgenerate

    (* ram_style = RAM_STYLE *)
    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/nlb_txq_split_fifo.sv
// -----------------------------------------------------------------------------
// nlb_txq_split_fifo
// Transmit-queue FIFO with the entry split in two: a narrow control field
// presented in a register at the head (T0 side), and a wide payload that is
// read from RAM only when the head is acked and appears DATA_LAT clocks later
// (TD side).
// Ports:
//   Clk    : clock, rising edge
//   Resetb : synchronous, active-low reset
//   fifo   : nlb_txq_split_fifo_if.slave (write/pop/flush inputs, head and
//            payload outputs, occupancy and status flags)
// -----------------------------------------------------------------------------
module nlb_txq_split_fifo
    import nlb_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH   = 552,
    parameter int    CTL_WIDTH    = 8,
    parameter int    DEPTH_BASE2  = 9,
    parameter int    DATA_LAT     = 2,
    parameter int    FULL_THRESH  = 2**DEPTH_BASE2 - 8,
    parameter int    EMPTY_THRESH = 1,
    parameter string RAM_STYLE    = "block"
) (
    input  logic                 Clk,
    input  logic                 Resetb,
    nlb_txq_split_fifo_if.slave  fifo
);

    localparam int DEPTH = 2**DEPTH_BASE2;
    localparam int CW    = DEPTH_BASE2 + 1;

    localparam logic [DEPTH_BASE2:0] CNT_FULL = CW'(DEPTH);
    localparam logic [DEPTH_BASE2:0] FULL_TH  = CW'(FULL_THRESH);
    localparam logic [DEPTH_BASE2:0] EMPTY_TH = CW'(EMPTY_THRESH);

    generate
        if (!data_lat_legal(DATA_LAT)) begin : g_bad_lat
            $error("nlb_txq_split_fifo: DATA_LAT=%0d outside %0d..%0d",
                   DATA_LAT, DATA_LAT_MIN, DATA_LAT_MAX);
        end
        if (DEPTH_BASE2 < 1 || DEPTH_BASE2 > MAX_DEPTH_BASE2) begin : g_bad_depth
            $error("nlb_txq_split_fifo: DEPTH_BASE2=%0d unsupported", DEPTH_BASE2);
        end
        if (CTL_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
            $error("nlb_txq_split_fifo: CTL_WIDTH and DATA_WIDTH must be >= 1");
        end
        if (FULL_THRESH < 0 || FULL_THRESH > DEPTH ||
            EMPTY_THRESH < 0 || EMPTY_THRESH > DEPTH) begin : g_bad_thresh
            $error("nlb_txq_split_fifo: thresholds must lie in 0..2**DEPTH_BASE2");
        end
    endgenerate

    logic [DEPTH_BASE2-1:0] wr_ptr;
    logic [DEPTH_BASE2-1:0] rd_ptr;
    logic [DEPTH_BASE2-1:0] rd_ptr_next;
    logic [DEPTH_BASE2:0]   count_r;
    logic [DEPTH_BASE2:0]   count_next;
    logic                   full_r;
    logic                   empty_r;
    logic                   alm_full_r;
    logic                   alm_empty_r;
    logic                   t0_v_r;
    logic                   overflow_r;
    logic                   underflow_r;
    logic                   wr_accept;
    logic                   pop_accept;
    logic                   head_fill;
    logic [CTL_WIDTH-1:0]   ctl_next;
    logic [CTL_WIDTH-1:0]   t0_ctl_r;
    logic [CTL_WIDTH-1:0]   ctl_mem [DEPTH];
    logic [DATA_LAT-1:0]    td_v;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic [DATA_WIDTH-1:0]  td_data;

    // A head entry exists exactly when t0_v_r is set, so pops qualify on it.
    // head_fill marks the case where the entry that becomes the new head is
    // the one being written right now, so it must bypass the control array.
    always_comb begin
        wr_accept   = fifo.fifo_wen && !full_r && !fifo.fifo_flush;
        pop_accept  = fifo.fifo_rdack && t0_v_r && !fifo.fifo_flush;
        rd_ptr_next = rd_ptr + DEPTH_BASE2'(pop_accept);
        head_fill   = wr_accept && (count_r == CW'(pop_accept));
        ctl_next    = head_fill ? fifo.fifo_ctlin : ctl_mem[rd_ptr_next];
        if (fifo.fifo_flush) begin
            count_next = '0;
        end else begin
            count_next = count_r + CW'(wr_accept) - CW'(pop_accept);
        end
    end

    // Pointers, occupancy and every status flag are registered from the
    // next-state count so they all move together.
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            alm_full_r  <= 1'b0;
            alm_empty_r <= 1'b1;
            t0_v_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (fifo.fifo_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + DEPTH_BASE2'(wr_accept);
                rd_ptr <= rd_ptr_next;
            end
            count_r     <= count_next;
            full_r      <= (count_next == CNT_FULL);
            empty_r     <= (count_next == '0);
            alm_full_r  <= (count_next >= FULL_TH);
            alm_empty_r <= (count_next <= EMPTY_TH);
            t0_v_r      <= (count_next != '0);
            // Sticky errors: a set in the same cycle as err_clr wins.
            overflow_r  <= (fifo.fifo_wen && full_r) || (overflow_r && !fifo.err_clr);
            underflow_r <= (fifo.fifo_rdack && !t0_v_r) || (underflow_r && !fifo.err_clr);
        end
    end

    // Control storage and the head register are unreset; their contents are
    // only meaningful while t0_v_r is set.
    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            ctl_mem[wr_ptr] <= fifo.fifo_ctlin;
        end
        t0_ctl_r <= ctl_next;
    end

    // Stage 0 lines up with the RAM's registered output; the last stage is
    // the TD strobe. Flush leaves strobes in flight alone, reset kills them.
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            td_v <= '0;
        end else begin
            td_v[0] <= pop_accept;
            for (int k = 1; k < DATA_LAT; k++) begin
                td_v[k] <= td_v[k-1];
            end
        end
    end

    nlb_sdp_ram #(
        .WIDTH     (DATA_WIDTH),
        .ADDR_BITS (DEPTH_BASE2),
        .RAM_STYLE (RAM_STYLE)
    ) u_payload_ram (
        .Clk     (Clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (fifo.fifo_din),
        .rd_en   (pop_accept),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    generate
        if (DATA_LAT == 1) begin : g_no_extra
            assign td_data = ram_rdata;
        end else begin : g_extra
            logic [DATA_WIDTH-1:0] stage [DATA_LAT-1];

            always_ff @(posedge Clk) begin
                stage[0] <= ram_rdata;
                for (int k = 1; k < DATA_LAT - 1; k++) begin
                    stage[k] <= stage[k-1];
                end
            end

            assign td_data = stage[DATA_LAT-2];
        end
    endgenerate

    assign fifo.T0_ctlout = t0_ctl_r;
    assign fifo.T0_dout_v = t0_v_r;
    assign fifo.TD_dout   = td_data;
    assign fifo.TD_dout_v = td_v[DATA_LAT-1];
    assign fifo.count     = count_r;
    assign fifo.full      = full_r;
    assign fifo.empty     = empty_r;
    assign fifo.almFull   = alm_full_r;
    assign fifo.almEmpty  = alm_empty_r;
    assign fifo.overflow  = overflow_r;
    assign fifo.underflow = underflow_r;

endmodule

// File: tb/tb_nlb_txq_split_fifo.sv
// -----------------------------------------------------------------------------
// tb_nlb_txq_split_fifo
// Drives three copies of nlb_txq_split_fifo (DATA_LAT 1, 2, 3, depth 8) with
// the same directed input sequence. A queue model tracks the expected head,
// occupancy and flags; expected TD payloads are queued at pop time with the
// cycle they are due and are matched by a separate monitor.
// -----------------------------------------------------------------------------
module tb_nlb_txq_split_fifo;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int DB = 3;
    localparam int FT = 6;
    localparam int ET = 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } td_t;

    logic Clk = 1'b0;
    logic Resetb;

    always #5 Clk = ~Clk;

    nlb_txq_split_fifo_if #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB)) if_l1 ();
    nlb_txq_split_fifo_if #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB)) if_l2 ();
    nlb_txq_split_fifo_if #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB)) if_l3 ();

    // The latency-1 and latency-3 copies follow the inputs driven on if_l2.
    assign if_l1.fifo_din   = if_l2.fifo_din;
    assign if_l1.fifo_ctlin = if_l2.fifo_ctlin;
    assign if_l1.fifo_wen   = if_l2.fifo_wen;
    assign if_l1.fifo_rdack = if_l2.fifo_rdack;
    assign if_l1.fifo_flush = if_l2.fifo_flush;
    assign if_l1.err_clr    = if_l2.err_clr;
    assign if_l3.fifo_din   = if_l2.fifo_din;
    assign if_l3.fifo_ctlin = if_l2.fifo_ctlin;
    assign if_l3.fifo_wen   = if_l2.fifo_wen;
    assign if_l3.fifo_rdack = if_l2.fifo_rdack;
    assign if_l3.fifo_flush = if_l2.fifo_flush;
    assign if_l3.err_clr    = if_l2.err_clr;

    nlb_txq_split_fifo #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB), .DATA_LAT(1),
                         .FULL_THRESH(FT), .EMPTY_THRESH(ET))
        dut_l1 (.Clk(Clk), .Resetb(Resetb), .fifo(if_l1));
    nlb_txq_split_fifo #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB), .DATA_LAT(2),
                         .FULL_THRESH(FT), .EMPTY_THRESH(ET))
        dut_l2 (.Clk(Clk), .Resetb(Resetb), .fifo(if_l2));
    nlb_txq_split_fifo #(.DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB), .DATA_LAT(3),
                         .FULL_THRESH(FT), .EMPTY_THRESH(ET))
        dut_l3 (.Clk(Clk), .Resetb(Resetb), .fifo(if_l3));

    logic [CW-1:0] mdl_ctl [$];
    logic [DW-1:0] mdl_dat [$];
    td_t           td_q [3][$];
    bit            mdl_ovf = 1'b0;
    bit            mdl_unf = 1'b0;
    bit            mon_en  = 1'b0;
    int            cyc     = 0;
    int            peak    = 0;
    int            checks  = 0;
    int            errors  = 0;

    // Cycle index: during cycle c, cyc == c; a pop issued in cycle c is due
    // on TD in cycle c + DATA_LAT.
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Matches one copy's TD strobe against the front of its expected queue,
    // and flags any expected strobe whose cycle has already passed.
    task automatic checkTd(input int lane, input logic v, input logic [DW-1:0] d);
        td_t e;
        if (td_q[lane].size() > 0 && td_q[lane][0].due < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL td_missing lat%0d: no TD_dout_v, required at cycle %0d (now %0d)",
                     lane + 1, td_q[lane][0].due, cyc);
            void'(td_q[lane].pop_front());
        end
        if (v !== 1'b0) begin
            checks++;
            if (td_q[lane].size() == 0) begin
                errors++;
                $display("[TB] FAIL td_unexpected lat%0d: TD_dout_v=%b data %0h, none expected (cycle %0d)",
                         lane + 1, v, d, cyc);
            end else begin
                e = td_q[lane].pop_front();
                if (d !== e.data || e.due != cyc) begin
                    errors++;
                    $display("[TB] FAIL td_data lat%0d: got %0h at cycle %0d, expected %0h at cycle %0d",
                             lane + 1, d, cyc, e.data, e.due);
                end
            end
        end
    endtask

    // Monitor: half a clock after each edge compare the main copy against
    // the queue model and drain the TD scoreboards of all three copies.
    always @(negedge Clk) begin
        if (mon_en) begin
            checkOutput("count",     32'(if_l2.count),     mdl_ctl.size());
            checkOutput("full",      32'(if_l2.full),      32'(mdl_ctl.size() == 2**DB));
            checkOutput("empty",     32'(if_l2.empty),     32'(mdl_ctl.size() == 0));
            checkOutput("almFull",   32'(if_l2.almFull),   32'(mdl_ctl.size() >= FT));
            checkOutput("almEmpty",  32'(if_l2.almEmpty),  32'(mdl_ctl.size() <= ET));
            checkOutput("T0_dout_v", 32'(if_l2.T0_dout_v), 32'(mdl_ctl.size() > 0));
            checkOutput("overflow",  32'(if_l2.overflow),  32'(mdl_ovf));
            checkOutput("underflow", 32'(if_l2.underflow), 32'(mdl_unf));
            if (mdl_ctl.size() > 0) begin
                checkOutput("T0_ctlout", 32'(if_l2.T0_ctlout), 32'(mdl_ctl[0]));
            end
            if (int'(if_l2.count) > peak) peak = int'(if_l2.count);
            checkTd(0, if_l1.TD_dout_v, if_l1.TD_dout);
            checkTd(1, if_l2.TD_dout_v, if_l2.TD_dout);
            checkTd(2, if_l3.TD_dout_v, if_l3.TD_dout);
        end
    end

    // One clock of stimulus; the model advances on the same edge as the DUTs.
    task automatic applyStimulus(input logic wen, input logic [CW-1:0] ctl, input logic [DW-1:0] din,
                                 input logic ack, input logic flush, input logic clr);
        int  c;
        bit  t0v;
        bit  isfull;
        bit  wa;
        bit  pa;
        td_t e;
        if_l2.fifo_wen   = wen;
        if_l2.fifo_ctlin = ctl;
        if_l2.fifo_din   = din;
        if_l2.fifo_rdack = ack;
        if_l2.fifo_flush = flush;
        if_l2.err_clr    = clr;
        c      = cyc;
        t0v    = mdl_ctl.size() > 0;
        isfull = mdl_ctl.size() == 2**DB;
        wa     = wen && !isfull && !flush;
        pa     = ack && t0v && !flush;
        @(posedge Clk);
        mdl_ovf = (wen && isfull) || (mdl_ovf && !clr);
        mdl_unf = (ack && !t0v) || (mdl_unf && !clr);
        if (flush) begin
            mdl_ctl.delete();
            mdl_dat.delete();
        end else begin
            if (pa) begin
                for (int l = 0; l < 3; l++) begin
                    e.data = mdl_dat[0];
                    e.due  = c + l + 1;
                    td_q[l].push_back(e);
                end
                void'(mdl_ctl.pop_front());
                void'(mdl_dat.pop_front());
            end
            if (wa) begin
                mdl_ctl.push_back(ctl);
                mdl_dat.push_back(din);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset for one edge: strobes already due by this cycle have been seen,
    // later ones are discarded along with every stored entry.
    task automatic applyReset();
        int c;
        if_l2.fifo_wen   = 1'b0;
        if_l2.fifo_rdack = 1'b0;
        if_l2.fifo_flush = 1'b0;
        if_l2.err_clr    = 1'b0;
        Resetb = 1'b0;
        c = cyc;
        @(posedge Clk);
        mdl_ctl.delete();
        mdl_dat.delete();
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        for (int l = 0; l < 3; l++) begin
            while (td_q[l].size() > 0 && td_q[l][td_q[l].size()-1].due > c) begin
                void'(td_q[l].pop_back());
            end
        end
        #1;
        Resetb = 1'b1;
    endtask

    initial begin
        Resetb           = 1'b0;
        if_l2.fifo_wen   = 1'b0;
        if_l2.fifo_ctlin = '0;
        if_l2.fifo_din   = '0;
        if_l2.fifo_rdack = 1'b0;
        if_l2.fifo_flush = 1'b0;
        if_l2.err_clr    = 1'b0;
        repeat (2) @(posedge Clk);
        applyReset();
        mon_en = 1'b1;

        checkOutput("rst count",     32'(if_l2.count),     0);
        checkOutput("rst empty",     32'(if_l2.empty),     1);
        checkOutput("rst full",      32'(if_l2.full),      0);
        checkOutput("rst almFull",   32'(if_l2.almFull),   0);
        checkOutput("rst almEmpty",  32'(if_l2.almEmpty),  1);
        checkOutput("rst T0_dout_v", 32'(if_l2.T0_dout_v), 0);
        checkOutput("rst TD_dout_v", 32'(if_l2.TD_dout_v), 0);
        checkOutput("rst overflow",  32'(if_l2.overflow),  0);
        checkOutput("rst underflow", 32'(if_l2.underflow), 0);

        // Single entry through an empty FIFO, payload checked on all latencies.
        applyStimulus(1'b1, 8'h5A, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        checkOutput("lat1 T0_dout_v", 32'(if_l1.T0_dout_v), 1);
        checkOutput("lat1 T0_ctlout", 32'(if_l1.T0_ctlout), 32'h5A);
        checkOutput("lat2 T0_ctlout", 32'(if_l2.T0_ctlout), 32'h5A);
        checkOutput("lat3 T0_ctlout", 32'(if_l3.T0_ctlout), 32'h5A);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Fill to full, one dropped write, then drain in order.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, CW'(16 + i), DW'(16'h1000 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("fill full",    32'(if_l2.full),      1);
        checkOutput("fill count",   32'(if_l2.count),     8);
        checkOutput("fill head",    32'(if_l2.T0_ctlout), 32'h10);
        applyStimulus(1'b1, 8'hEE, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf flag",     32'(if_l2.overflow),  1);
        checkOutput("ovf count",    32'(if_l2.count),     8);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf cleared",  32'(if_l2.overflow),  0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain empty",  32'(if_l2.empty),     1);
        idle(4);

        // Count 1 with write and pop together: new entry becomes the head.
        applyStimulus(1'b1, 8'h31, 16'h3100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 16'h7700, 1'b1, 1'b0, 1'b0);
        checkOutput("swap T0_dout_v", 32'(if_l2.T0_dout_v), 1);
        checkOutput("swap T0_ctlout", 32'(if_l2.T0_ctlout), 32'h77);
        checkOutput("swap count",     32'(if_l2.count),     1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Streaming at one entry per clock across three pointer wraps.
        applyStimulus(1'b1, 8'h40, 16'h4000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 16'h4001, 1'b0, 1'b0, 1'b0);
        peak = 0;
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, CW'(8'h42 + i), DW'(16'h4002 + i), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkOutput("stream peak count", 32'(peak), 2);

        // Flush at count 5 with wen and rdack; the earlier pop still completes.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, CW'(8'h50 + i), DW'(16'h5000 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("preflush count", 32'(if_l2.count), 5);
        applyStimulus(1'b1, 8'h99, 16'h9999, 1'b1, 1'b1, 1'b0);
        checkOutput("flush count",     32'(if_l2.count),     0);
        checkOutput("flush T0_dout_v", 32'(if_l2.T0_dout_v), 0);
        checkOutput("flush almEmpty",  32'(if_l2.almEmpty),  1);
        applyStimulus(1'b1, 8'h66, 16'h6666, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush head",  32'(if_l2.T0_ctlout), 32'h66);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Underflow set, cleared, and set-wins-over-clear.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("unf set",       32'(if_l2.underflow), 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("unf cleared",   32'(if_l2.underflow), 0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("unf set wins",  32'(if_l2.underflow), 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation drops entries and strobes not yet due.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, CW'(8'h80 + i), DW'(16'h8000 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyReset();
        checkOutput("midrst count",     32'(if_l2.count),     0);
        checkOutput("midrst T0_dout_v", 32'(if_l2.T0_dout_v), 0);
        idle(5);

        checkOutput("td lat1 drained", td_q[0].size(), 0);
        checkOutput("td lat2 drained", td_q[1].size(), 0);
        checkOutput("td lat3 drained", td_q[2].size(), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
